// File: rtl/cmp_seq_pkg.sv
// rtl/cmp_seq_pkg.sv - shared types and sizing helpers for the sequential comparator
package cmp_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic int slices_width(input int ns);
      return $clog2(ns) + 1;
   endfunction

   function automatic bit width_ok(input int w);
      return (w % 2 == 0) && (w >= 2);
   endfunction

endpackage

// File: rtl/comparator_2bit.sv
// rtl/comparator_2bit.sv - combinational 2-bit magnitude comparator slice
module comparator_2bit (
   input  logic A1,
   input  logic A0,
   input  logic B1,
   input  logic B0,
   output logic G,
   output logic E,
   output logic L
);

   logic hi_eq;

   assign hi_eq = ~(A1 ^ B1);
   assign G = (A1 & ~B1) | (hi_eq & A0 & ~B0);
   assign L = (~A1 & B1) | (hi_eq & ~A0 & B0);
   assign E = hi_eq & ~(A0 ^ B0);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// rtl/cmp_seq_ctrl.sv - MSB-first pairwise comparator sequencer with early exit
module cmp_seq_ctrl
   import cmp_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   input  logic [WIDTH-1:0]                       A,
   input  logic [WIDTH-1:0]                       B,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   G,
   output logic                                   E,
   output logic                                   L,
   output logic [slices_width(WIDTH/2)-1:0]       slices
);

   localparam int NS = WIDTH / 2;
   localparam int SW = slices_width(NS);
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;

   if (!width_ok(WIDTH)) begin : g_width_check
      $error("cmp_seq_ctrl: WIDTH must be even and at least 2");
   end

   state_t           state, state_nx;
   logic [IW-1:0]    idx, idx_nx;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       a_pair, b_pair;
   logic             cg, ce, cl;
   logic             fin;
   logic             load;

   assign a_pair = a_q[{idx, 1'b0} +: 2];
   assign b_pair = b_q[{idx, 1'b0} +: 2];

   comparator_2bit u_slice (
      .A1 (a_pair[1]),
      .A0 (a_pair[0]),
      .B1 (b_pair[1]),
      .B0 (b_pair[0]),
      .G  (cg),
      .E  (ce),
      .L  (cl)
   );

   assign busy = (state == SCAN);
   assign load = (state == IDLE) && start;

   // An equal pair at idx 0 ends the scan; the slice already reports 010 there.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      fin      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = SCAN;
               idx_nx   = IW'(NS - 1);
            end
         end
         SCAN: begin
            if (!ce || idx == '0) begin
               fin      = 1'b1;
               state_nx = IDLE;
            end else begin
               idx_nx = idx - IW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         done   <= 1'b0;
         G      <= 1'b0;
         E      <= 1'b0;
         L      <= 1'b0;
         slices <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         done  <= fin;
         if (load) begin
            a_q <= A;
            b_q <= B;
         end
         if (fin) begin
            G      <= cg;
            E      <= ce;
            L      <= cl;
            slices <= SW'(NS) - SW'(idx);
         end
      end
   end

endmodule
